mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter LAT, default 2: wait cycles inserted before each access completes (0..15).
REQ-002 Parameter DEPTH, default 1024: storage size in 32-bit words, power of two.
REQ-003 Ports SHALL be:
CLK  in  1  single clock, rising-edge.
RST  in  1  reset; synchronous and active-high.
imemREN  in  1  instruction read request.
imemaddr  in  32  instruction byte address.
imemload  out  32  instruction read data.
ihit  out  1  instruction access done, one-cycle pulse.
dmemREN  in  1  data read request.
dmemWEN  in  1  data write request.
dmemaddr  in  32  data byte address.
dmemstore  in  32  data write value.
dmemload  out  32  data read data.
dhit  out  1  data access done, one-cycle pulse.
halt  in  1  datapath halted.
flushed  out  1  halt seen, no access outstanding.

Function
REQ-004 FSM SHALL have states IDLE, BUSY_I, BUSY_D.
REQ-005 In IDLE, with dmemWEN or dmemREN high, SHALL latch address, store data and op, load wait counter with LAT, and go to BUSY_D.
REQ-006 In IDLE, with no data request, imemREN high and not halted, SHALL latch address, load counter with LAT, and go to BUSY_I.
REQ-007 Data requests SHALL take priority over instruction requests at IDLE.
REQ-008 With dmemWEN and dmemREN both high, the access SHALL be a write.
REQ-009 In BUSY_x with counter nonzero, the counter SHALL decrement.
REQ-010 In BUSY_x with counter zero, SHALL perform the access, register read data into imemload/dmemload, pulse ihit/dhit for exactly that one cycle, and return to IDLE.
REQ-011 Hit SHALL occur LAT+1 cycles after the acceptance cycle (LAT=0: the next cycle).
REQ-012 A write SHALL commit to storage at the edge ending its hit cycle; dmemload SHALL be unchanged by writes.
REQ-013 If the requesting enable drops while BUSY_x, SHALL abort to IDLE at the next edge: no hit, no write.
REQ-014 Word index SHALL be addr[log2(DEPTH)+1:2]; addr[1:0] ignored; upper bits ignored (wrap modulo DEPTH).
REQ-015 imemload/dmemload SHALL hold their last returned value until the next hit of the same port.
REQ-016 halt high at any edge SHALL set a sticky halted flag; once halted, no new instruction request is accepted and data requests are still served.
REQ-017 flushed SHALL be high while halted is set and state is IDLE; it is registered.
REQ-018 ihit and dhit SHALL never be high in the same cycle.

Reset
REQ-019 RST high at an edge SHALL force IDLE, counter 0, halted 0, ihit 0, dhit 0, flushed 0, imemload 0, dmemload 0.
REQ-020 Reset during BUSY_D write SHALL abort the write; storage contents are not reset.

Configuration
REQ-021 Macro MEM_RESPONDER_STATS_EN SHALL, when defined, add outputs icount and dcount (32-bit each) counting ihit and dhit pulses; both reset to 0 and wrap at 2^32.
REQ-022 Without MEM_RESPONDER_STATS_EN, these ports and counters SHALL be absent and all other behaviour is identical.

Verification
REQ-023 LAT=2: write 0xDEADBEEF to 0x40, then read 0x40 -> dhit 3 cycles after each acceptance; dmemload=0xDEADBEEF.
REQ-024 imemREN and dmemREN both high at IDLE -> data served first (dhit), then ihit LAT+1 cycles after the second acceptance.
REQ-025 LAT=3: dmemWEN 0x8 value 0x1234 dropped after 1 cycle -> no dhit; later read of 0x8 returns the prior value.
REQ-026 DEPTH=1024: write 0x5A to 0x1000, read 0x0 -> returns 0x5A (wrap).
REQ-027 halt pulse with imemREN held high -> no further ihit; flushed=1 once IDLE; a dmemREN is still served with dhit.
REQ-028 RST asserted mid-BUSY_D write -> outputs at reset values next cycle; target word unchanged; with STATS_EN, icount=dcount=0.

Source files
------------

// File: rtl/mem_responder_if.sv
// Memory-side bus between a datapath (master) and the mem_responder (slave).
interface mem_responder_if;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic [31:0] imemload;
   logic        ihit;
   logic        dmemREN;
   logic        dmemWEN;
   logic [31:0] dmemaddr;
   logic [31:0] dmemstore;
   logic [31:0] dmemload;
   logic        dhit;
   logic        halt;
   logic        flushed;

   modport master (
      output imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      input  imemload, ihit, dmemload, dhit, flushed
   );

   modport slave (
      input  imemREN, imemaddr, dmemREN, dmemWEN, dmemaddr, dmemstore, halt,
      output imemload, ihit, dmemload, dhit, flushed
   );
endinterface

// File: rtl/mem_responder.sv
// Unified instruction/data memory model with programmable wait states.
// Data requests win over instruction requests; halt blocks new fetches.
// Optional hit counters (icount/dcount) are enabled by MEM_RESPONDER_STATS_EN.
module mem_responder #(
   parameter int unsigned LAT   = 2,
   parameter int unsigned DEPTH = 1024
) (
   input  logic              CLK,
   input  logic              RST,
   mem_responder_if.slave    bus
`ifdef MEM_RESPONDER_STATS_EN
   ,
   output logic [31:0]       icount,
   output logic [31:0]       dcount
`endif
);

   localparam int unsigned AW    = $clog2(DEPTH);
   localparam int unsigned CNT_W = 4;

   typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} state_t;

   state_t             state, state_n;
   logic [CNT_W-1:0]   cnt, cnt_n;
   logic [AW-1:0]      addr_q, addr_n;
   logic [31:0]        data_q, data_n;
   logic               wr_q, wr_n;
   logic               halted, halted_n;
   logic               ihit_n, dhit_n;
   logic               wr_commit;
   logic               d_en;
   logic [31:0]        mem [DEPTH];

   // Byte offset and bits above the storage range are deliberately ignored.
   logic unused_bits;
   assign unused_bits = ^{bus.imemaddr[31:AW+2], bus.imemaddr[1:0],
                          bus.dmemaddr[31:AW+2], bus.dmemaddr[1:0]};

   // Next-state, latch and hit decode; the hit cycle always completes.
   always_comb begin
      state_n   = state;
      cnt_n     = cnt;
      addr_n    = addr_q;
      data_n    = data_q;
      wr_n      = wr_q;
      wr_commit = 1'b0;
      d_en      = 1'b0;
      halted_n  = halted | bus.halt;
      case (state)
         IDLE: begin
            if (bus.dmemWEN || bus.dmemREN) begin
               state_n = BUSY_D;
               cnt_n   = CNT_W'(LAT);
               addr_n  = bus.dmemaddr[AW+1:2];
               data_n  = bus.dmemstore;
               wr_n    = bus.dmemWEN;
            end else if (bus.imemREN && !halted) begin
               state_n = BUSY_I;
               cnt_n   = CNT_W'(LAT);
               addr_n  = bus.imemaddr[AW+1:2];
               wr_n    = 1'b0;
            end
         end
         BUSY_I: begin
            if (cnt == '0) begin
               state_n = IDLE;
            end else if (!bus.imemREN) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         BUSY_D: begin
            d_en = wr_q ? bus.dmemWEN : bus.dmemREN;
            if (cnt == '0) begin
               state_n   = IDLE;
               wr_commit = wr_q;
            end else if (!d_en) begin
               state_n = IDLE;
               cnt_n   = '0;
            end else begin
               cnt_n = cnt - CNT_W'(1);
            end
         end
         default: begin
            state_n = IDLE;
            cnt_n   = '0;
         end
      endcase
      ihit_n = (state_n == BUSY_I) && (cnt_n == '0);
      dhit_n = (state_n == BUSY_D) && (cnt_n == '0);
   end

   // State, request latch and registered responses.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state        <= IDLE;
         cnt          <= '0;
         addr_q       <= '0;
         data_q       <= '0;
         wr_q         <= 1'b0;
         halted       <= 1'b0;
         bus.ihit     <= 1'b0;
         bus.dhit     <= 1'b0;
         bus.flushed  <= 1'b0;
         bus.imemload <= '0;
         bus.dmemload <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         addr_q      <= addr_n;
         data_q      <= data_n;
         wr_q        <= wr_n;
         halted      <= halted_n;
         bus.ihit    <= ihit_n;
         bus.dhit    <= dhit_n;
         bus.flushed <= halted_n && (state_n == IDLE);
         if (ihit_n) begin
            bus.imemload <= mem[addr_n];
         end
         if (dhit_n && !wr_n) begin
            bus.dmemload <= mem[addr_n];
         end
      end
   end

   // Storage write at the end of the hit cycle; contents survive reset.
   always_ff @(posedge CLK) begin
      if (!RST && wr_commit) begin
         mem[addr_q] <= data_q;
      end
   end

`ifdef MEM_RESPONDER_STATS_EN
   // Hit counters, free-running with natural wrap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         icount <= '0;
         dcount <= '0;
      end else begin
         if (ihit_n) icount <= icount + 32'd1;
         if (dhit_n) dcount <= dcount + 32'd1;
      end
   end
`endif

endmodule
